reg_file_sb: RTL

- Parametrised successor of the ID-stage register file.
- Provides NUM_RD combinational read ports, one synchronous write port, and a hardwired-zero register 0.
- Adds a per-register busy scoreboard. ID sets a bit when an instruction allocates a destination; WB clears it. Hazard logic uses the bits to stall on in-flight producers (load-use, multi-cycle MUL/DIV).

---
 rtl/reg_file_sb_pkg.sv | 20 ++
 rtl/reg_file_sb_if.sv | 38 +++
 rtl/reg_file_sb_scoreboard.sv | 63 ++++++
 rtl/reg_file_sb.sv | 88 ++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared defaults and flattened-port helpers for reg_file_sb
//
// Purpose : default sizes, the hardwired-zero register index and the helper
//           used to locate a port's slice inside a flattened bus.
// Ports   : none (package).
// Config  : REG_FILE_BYPASS_EN (consumed by reg_file_sb, not by this package).

package reg_file_sb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int REG_ZERO   = 0;

  // Low bit of port 'idx' inside a bus flattened as NUM * width.
  function automatic int slice_base(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - read/write/allocate bus of the scoreboarded register file
//
// Purpose : bundles the read ports, write port, scoreboard allocate and flush.
// Ports   : raddr/rdata/rbusy  NUM_RD flattened read ports
//           we/waddr/wd        synchronous write port (also clears busy)
//           alloc_en/alloc_addr mark a destination busy
//           flush              clear every busy bit
// Modports: master drives requests (ID/WB side), slave is the register file.

interface reg_file_sb_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
);

  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   raddr;
  logic [NUM_RD*XLEN-1:0] rdata;
  logic [NUM_RD-1:0]      rbusy;
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [XLEN-1:0]        wd;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_addr;
  logic                   flush;

  modport master (
    output raddr, we, waddr, wd, alloc_en, alloc_addr, flush,
    input  rdata, rbusy
  );

  modport slave (
    input  raddr, we, waddr, wd, alloc_en, alloc_addr, flush,
    output rdata, rbusy
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// rtl/reg_file_sb_scoreboard.sv - per-register busy bits with set/clear/flush priority
//
// Purpose : one busy bit per architectural register. Reset and flush clear all
//           bits; otherwise a write-back clears its destination and an
//           allocation sets its destination, allocation winning on a tie.
// Ports   : clk, rst          clock, synchronous active-high reset
//           flush             clear all bits, discarding a same-cycle alloc
//           set_en/set_addr   allocation (ID issue)
//           clr_en/clr_addr   write-back (WB)
//           raddr             flattened lookup addresses, NUM_RD ports
//           busy_rd           stored busy bit of each looked-up register

module rf_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_addr,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD-1:0]    busy_rd
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Clear first, then set: when WB and ID hit the same register in one cycle
  // the new producer is the one that remains in flight.
  always_comb begin
    busy_nxt = busy;
    if (clr_en && (clr_addr != ZERO_ADDR)) begin
      busy_nxt[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != ZERO_ADDR)) begin
      busy_nxt[set_addr] = 1'b1;
    end
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
    assign busy_rd[i] = busy[raddr[slice_base(i, AW) +: AW]];
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with combinational reads, one write port and busy scoreboard
//
// Purpose : NREGS x XLEN storage with register 0 hardwired to zero, NUM_RD
//           combinational read ports and a per-register busy scoreboard used
//           by hazard logic to stall on in-flight producers.
// Ports   : clk   rising-edge clock
//           rst   synchronous active-high reset (clears data and busy bits)
//           bus   reg_file_sb_if.slave (read ports, write port, alloc, flush)
// Config  : REG_FILE_BYPASS_EN - when defined, a read of the register being
//           written this cycle returns wd and reports not-busy (write-first
//           forwarding). When undefined, reads show stored contents only.

module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0]        regs [NREGS];
  logic                   wr_ok;
  logic [NUM_RD-1:0]      sb_busy;
  logic [NUM_RD*XLEN-1:0] rdata_all;
  logic [NUM_RD-1:0]      rbusy_all;

  assign wr_ok = bus.we && (bus.waddr != ZERO_ADDR);

  // Reset has priority, so a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wd;
    end
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .set_en   (bus.alloc_en),
    .set_addr (bus.alloc_addr),
    .clr_en   (bus.we),
    .clr_addr (bus.waddr),
    .raddr    (bus.raddr),
    .busy_rd  (sb_busy)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          fwd;

    assign ra  = bus.raddr[slice_base(i, AW) +: AW];
    // Forward only real writes; wr_ok already excludes register 0.
    assign fwd = BYPASS && wr_ok && (ra == bus.waddr);

    assign rdata_all[slice_base(i, XLEN) +: XLEN] =
        (ra == ZERO_ADDR) ? '0 :
        fwd               ? bus.wd :
                            regs[ra];

    // Forwarded data is arriving now, so the consumer need not stall.
    assign rbusy_all[i] = sb_busy[i] & ~fwd;
  end

  assign bus.rdata = rdata_all;
  assign bus.rbusy = rbusy_all;

endmodule
